// File: rtl/alu_pkg.sv
// Shared constants, ALU opcode encodings and sequencer state type.
package alu_pkg;
  localparam int WIDTH = 4;
  localparam int NREGS = 4;
  localparam int RW    = $clog2(NREGS);
  localparam int CNTW  = 3;

  // Opcode is {sel[2:0], cin}; odd codes above OP_NOT's neighbours are reserved.
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDC = 4'd3;
  localparam logic [3:0] OP_SUBB = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_XOR  = 4'd12;
  localparam logic [3:0] OP_NOT  = 4'd14;

  typedef enum logic [1:0] {IDLE, EXEC, WB} seq_state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// Command, preload, debug-read, ALU and completion signals of the sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RW-1:0]    cmd_rd;
  logic [RW-1:0]    cmd_ra;
  logic [RW-1:0]    cmd_rb;
  logic [CNTW-1:0]  cmd_cnt;
  logic             ld_en;
  logic [RW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [RW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_f;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_cnt,
    input  ld_en, ld_addr, ld_data, rd_addr, alu_f,
    output cmd_ready, rd_data, alu_a, alu_b, alu_sel, alu_cin, done, result, zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_cnt,
    output ld_en, ld_addr, ld_data, rd_addr, alu_f,
    input  cmd_ready, rd_data, alu_a, alu_b, alu_sel, alu_cin, done, result, zero
  );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: one write port, whole array exposed plus one read port.
module alu_regfile import alu_pkg::*; (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_we,
  input  logic [RW-1:0]                i_waddr,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic [RW-1:0]                i_raddr,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [NREGS-1:0][WIDTH-1:0]  o_regs
);
  logic [NREGS-1:0][WIDTH-1:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_mem <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_regs  = r_mem;
endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer: latches operands, drives an external ALU repeatedly,
// writes the final value back and pulses done.
module alu_sequencer import alu_pkg::*; (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);
  seq_state_t                  r_state, w_next;
  logic [WIDTH-1:0]            r_acc, r_bq, r_result;
  logic [3:0]                  r_op;
  logic [RW-1:0]               r_rd;
  logic [CNTW-1:0]             r_cnt;
  logic                        r_zero;
  logic                        w_we;
  logic [RW-1:0]               w_waddr;
  logic [WIDTH-1:0]            w_wdata;
  logic [NREGS-1:0][WIDTH-1:0] w_regs;
  logic                        w_accept;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid;

  // WB owns the write port; preloads only land while idle.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.ld_addr;
    w_wdata = bus.ld_data;
    if (r_state == WB) begin
      w_we    = 1'b1;
      w_waddr = r_rd;
      w_wdata = r_acc;
    end else if (r_state == IDLE) begin
      w_we    = bus.ld_en;
    end
  end

  alu_regfile u_rf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data),
    .o_regs  (w_regs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cmd_valid) w_next = EXEC;
      EXEC:    if (r_cnt == '0)   w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // result/zero are captured from the final ALU output so they are valid during WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_bq     <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_regs[bus.cmd_ra];
      r_bq  <= w_regs[bus.cmd_rb];
      r_op  <= bus.cmd_op;
      r_rd  <= bus.cmd_rd;
      r_cnt <= bus.cmd_cnt;
    end else if (r_state == EXEC) begin
      r_acc <= bus.alu_f;
      if (r_cnt == '0) begin
        r_result <= bus.alu_f;
        r_zero   <= (bus.alu_f == '0);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    bus.alu_cin = 1'b0;
    if (r_state == EXEC) begin
      bus.alu_a   = r_acc;
      bus.alu_b   = r_bq;
      bus.alu_sel = r_op[3:1];
      bus.alu_cin = r_op[0];
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.done      = (r_state == WB);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: behavioural ALU, timeline-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      4'd0:    r = a;
      4'd1:    r = a + 4'd1;
      4'd2:    r = a + b;
      4'd3:    r = a + b + 4'd1;
      4'd4:    r = a - b - 4'd1;
      4'd5:    r = a - b;
      4'd6:    r = a - 4'd1;
      4'd7:    r = b;
      4'd8:    r = a & b;
      4'd10:   r = a | b;
      4'd12:   r = a ^ b;
      4'd14:   r = ~a;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  always_comb bus.alu_f = alu_fn({bus.alu_sel, bus.alu_cin}, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index of each period, and for the active command the
  // period it started executing, the operand sequence and the period of done.
  int         cyc;
  int         m_N, m_cnt, m_done_cyc;
  logic [3:0] m_r [NREGS];
  logic [3:0] m_seq [9];
  logic [3:0] m_bq, m_op, m_pend, m_res;
  logic [1:0] m_rd;
  logic       m_zero;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; m_N = -1000; m_cnt = 0; m_done_cyc = -10;
      for (int i = 0; i < NREGS; i++) m_r[i] = 4'd0;
      m_res = 4'd0; m_zero = 1'b0; m_pend = 4'd0; m_bq = 4'd0; m_op = 4'd0; m_rd = 2'd0;
    end else begin
      logic       idle_prev;
      logic [3:0] a;
      cyc++;
      idle_prev = (cyc - 1) > m_done_cyc;
      if (cyc == m_done_cyc + 1) m_r[m_rd] = m_res;
      if (idle_prev && bus.cmd_valid) begin
        m_op = bus.cmd_op; m_rd = bus.cmd_rd; m_cnt = int'(bus.cmd_cnt);
        m_bq = m_r[bus.cmd_rb];
        a = m_r[bus.cmd_ra];
        for (int k = 0; k <= m_cnt; k++) begin
          m_seq[k] = a;
          a = alu_fn(m_op, a, m_bq);
        end
        m_pend = a;
        m_N = cyc;
        m_done_cyc = cyc + m_cnt + 1;
      end
      if (idle_prev && bus.ld_en) m_r[bus.ld_addr] = bus.ld_data;
      if (cyc == m_done_cyc) begin
        m_res = m_pend;
        m_zero = (m_pend == 4'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic in_exec;
    in_exec = (cyc >= m_N) && (cyc <= m_N + m_cnt);
    chk("cmd_ready", int'(bus.cmd_ready), int'(cyc > m_done_cyc));
    chk("done", int'(bus.done), int'(cyc == m_done_cyc));
    chk("result", int'(bus.result), int'(m_res));
    chk("zero", int'(bus.zero), int'(m_zero));
    chk("rd_data", int'(bus.rd_data), int'(m_r[bus.rd_addr]));
    chk("alu_a", int'(bus.alu_a), in_exec ? int'(m_seq[cyc - m_N]) : 0);
    chk("alu_b", int'(bus.alu_b), in_exec ? int'(m_bq) : 0);
    chk("alu_op", int'({bus.alu_sel, bus.alu_cin}), in_exec ? int'(m_op) : 0);
  end

  task automatic ld(input int addr, input int data);
    bus.ld_en = 1'b1; bus.ld_addr = 2'(addr); bus.ld_data = 4'(data);
    @(posedge clk); #2;
    bus.ld_en = 1'b0;
  endtask

  // Present a command (and any preload already set up) until it is accepted;
  // returns in the first execute period.
  task automatic issue(input int op, input int rd, input int ra, input int rb, input int cnt);
    bit ok = 0;
    bus.cmd_op = 4'(op); bus.cmd_rd = 2'(rd); bus.cmd_ra = 2'(ra); bus.cmd_rb = 2'(rb);
    bus.cmd_cnt = 3'(cnt); bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL issue_timeout: cmd_ready never rose"); end
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0; bus.ld_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int cnt, input int exp);
    bit ok = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1;
        chk({name, "_latency"}, k, cnt + 2);
        chk({name, "_result"}, int'(bus.result), exp);
        chk({name, "_zero"}, int'(bus.zero), int'(exp == 0));
        break;
      end
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL %s_timeout: done never seen", name); end
  endtask

  task automatic peek(input string name, input int addr, input int exp);
    bus.rd_addr = 2'(addr); #1;
    chk(name, int'(bus.rd_data), exp);
  endtask

  initial begin
    bit rdy;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_ra = 0; bus.cmd_rb = 0; bus.cmd_cnt = 0;
    bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.rd_addr = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < NREGS; i++) peek("reset_reg", i, 0);
    chk("reset_ready", int'(bus.cmd_ready), 1);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_sel", int'(bus.alu_sel), 0);

    ld(0, 5); ld(1, 3);
    issue(2, 2, 0, 1, 0);
    #1;
    chk("add_sel", int'(bus.alu_sel), 1);
    chk("add_cin", int'(bus.alu_cin), 0);
    wait_done("add", 0, 8);
    @(posedge clk); #2;
    peek("add_wb", 2, 8);

    ld(0, 14);
    issue(1, 3, 0, 0, 3);
    wait_done("inc_wrap", 3, 2);
    @(posedge clk); #2;
    peek("inc_wb", 3, 2);

    ld(0, 3); ld(1, 5);
    issue(5, 0, 0, 1, 0);
    wait_done("sub", 0, 14);
    @(posedge clk); #2;
    peek("sub_wb", 0, 14);
    issue(12, 2, 1, 1, 0);
    wait_done("xor_self", 0, 0);

    issue(2, 1, 0, 0, 7);
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b1;
    #1 chk("abort_done", int'(bus.done), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) peek("abort_reg", i, 0);
    chk("abort_ready", int'(bus.cmd_ready), 1);

    ld(0, 2);
    issue(2, 1, 0, 0, 2);
    bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 4'd9;
    @(posedge clk); #2;
    bus.ld_data = 4'd7;
    issue(0, 3, 0, 0, 0);
    wait_done("same_cycle_ld", 0, 2);
    @(posedge clk); #2;
    peek("ld_after_cmd", 0, 7);
    peek("held_prev_wb", 1, 8);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk); rdy = bus.cmd_ready;
      @(posedge clk); #2;
      if (bus.cmd_valid && rdy) bus.cmd_valid = 1'b0;
      bus.rd_addr = 2'($urandom_range(0, 3));
      bus.ld_en   = ($urandom_range(0, 2) == 0);
      bus.ld_addr = 2'($urandom_range(0, 3));
      bus.ld_data = 4'($urandom_range(0, 15));
      if (!bus.cmd_valid && $urandom_range(0, 1) == 1) begin
        bus.cmd_op  = 4'($urandom_range(0, 15));
        bus.cmd_rd  = 2'($urandom_range(0, 3));
        bus.cmd_ra  = 2'($urandom_range(0, 3));
        bus.cmd_rb  = 2'($urandom_range(0, 3));
        bus.cmd_cnt = 3'($urandom_range(0, 7));
        bus.cmd_valid = 1'b1;
      end
    end
    bus.cmd_valid = 1'b0; bus.ld_en = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-driven controller that sits on the initiator side of the 4-bit ALU. It owns a small register file, decodes a command into the ALU's {sel, cin} opcode and operands, and feeds the ALU result back for repeated application. It writes the final value to a destination register and reports completion. It sits between a command source (test harness or future instruction decoder) and a combinational ALU instance placed alongside it.

Parameters:
WIDTH, 4, data width of registers and ALU operands
NREGS, 4, register-file depth (index width RW = $clog2(NREGS) = 2)
CNTW, 3, iteration-count width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  4  ALU opcode {sel[2:0], cin}
cmd_rd  in  RW  destination register
cmd_ra  in  RW  A-operand source register
cmd_rb  in  RW  B-operand source register
cmd_cnt  in  CNTW  extra iterations (total applications = cmd_cnt+1)
ld_en  in  1  register preload strobe
ld_addr  in  RW  preload address
ld_data  in  WIDTH  preload data
rd_addr  in  RW  debug read address
rd_data  out  WIDTH  combinational read of R[rd_addr]
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_sel  out  3  ALU select
alu_cin  out  1  ALU carry/modifier bit
alu_f  in  WIDTH  ALU result, combinational from alu_* outputs
done  out  1  one-cycle completion pulse
result  out  WIDTH  final value, valid while done=1, held afterward
zero  out  1  result==0, updated with done

Behaviour:
- Reset (async, active-high): state=IDLE; all R[i]=0; acc, bq, cnt, op=0; done=0; result=0; zero=0; alu_a/b/sel/cin=0; cmd_ready=1 while in IDLE.
- FSM states: IDLE, EXEC, WB.
- IDLE: cmd_ready=1; alu_* driven 0.
  - If ld_en=1: R[ld_addr]<=ld_data.
  - If cmd_valid=1: latch acc<=R[ra], bq<=R[rb], op, rd, and cnt<=cmd_cnt, then go to EXEC.
  - ld_en and cmd_valid in the same cycle: both act. The command samples pre-write register values.
- EXEC: alu_a=acc, alu_b=bq, alu_sel=op[3:1], alu_cin=op[0].
  - Each cycle: acc<=alu_f.
  - If cnt==0, go to WB; else cnt<=cnt-1.
- WB: R[rd]<=acc, done=1 (Moore, exactly one cycle), result<=acc, zero<=(acc==0). Then go to IDLE.
- Latency: command accepted at edge N. EXEC spans cycles N+1 .. N+1+cmd_cnt. done is high in cycle N+2+cmd_cnt. Minimum command period is 3 cycles.
- ld_en outside IDLE is ignored. cmd_valid outside IDLE is not accepted; the source holds the command until cmd_ready.
- Arithmetic is purely the ALU's, modulo 2^WIDTH. The sequencer adds no carry or overflow state. Reserved opcodes (9, 11, 13, 15) are forwarded unchanged; the ALU yields 0.
- ra==rb, and rd equal to ra or rb, are legal. Operands are latched at accept, so a write-back never affects an in-flight command.
- rd_data is combinational and reflects the WB write from the cycle after WB.
- Reset asserted mid-EXEC or mid-WB: immediate abort, no done pulse, register file cleared.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_PASS=0, OP_INC=1, OP_ADD=2, OP_ADDC=3, OP_SUBB=4, OP_SUB=5, OP_DEC=6, OP_AND=8, OP_OR=10, OP_XOR=12, OP_NOT=14
  - typedef enum seq_state_t {IDLE, EXEC, WB}
  - WIDTH/NREGS constants
- One sub-module: alu_regfile (NREGS×WIDTH, one write port with async reset, one combinational read port). It is instantiated once; the sequencer muxes the write port between ld and WB, and the ra, rb and rd_addr reads come from array reads.
- The ALU is instantiated by the bench/top, not inside the sequencer.

Test Plan:
- Reset, then read R0..R3 via rd_addr -> all 0, cmd_ready=1, done=0, alu_sel=0.
- ld R0=5, R1=3; cmd op=2, rd=2, ra=0, rb=1, cnt=0 accepted at N -> alu_sel=1, alu_cin=0 in N+1; done in N+2; result=8, zero=0; rd_data(2)=8.
- R0=14; cmd op=1 (inc), rd=3, ra=0, cnt=3 -> acc sequence 15, 0, 1, 2; done at N+5; result=2; R3=2.
- R0=3, R1=5; op=5 (sub), rd=0 -> result=14, R0=14. Then op=12 (xor), ra=rb=1 -> result=0, zero=1.
- Command with cnt=7; assert reset in cycle N+3 -> no done, all regs 0, cmd_ready=1 after release.
- ld_en R0=9 during EXEC -> ignored. cmd_valid held through busy -> accepted only at next IDLE. Same-cycle ld R0=7 with cmd ra=0 (R0 was 2), op=0 -> result=2, then R0=7.
